// File: rtl/smoosh_pkg.sv
// Shared types and constants for the fighter design: controller scan states
// and the pad bit position of each button.
package smoosh_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } pad_state_t;

  localparam int BTN_ATK    = 0;
  localparam int BTN_SHIELD = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int PAD_BITS = 8;

endpackage

// File: rtl/pad_tick_gen.sv
// Free-running poll counter; tick is high for the one cycle the counter
// holds its terminal value.
module pad_tick_gen #(
  parameter int POLL_PERIOD = 833333
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int CW = $clog2(POLL_PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(POLL_PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/pad_reader.sv
// NES-style controller reader: latches the pad, clocks out 8 serial bits,
// and publishes debounced button levels plus rising-edge flags once per poll.
module pad_reader
  import smoosh_pkg::*;
#(
  parameter int CLK_DIV     = 300,
  parameter int POLL_PERIOD = 833333
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic       btn_atk,
  output logic       btn_shield,
  output logic       btn_select,
  output logic       btn_start,
  output logic       btn_up,
  output logic       btn_down,
  output logic       btn_left,
  output logic       btn_right,
  output logic [7:0] btn_pressed,
  output logic       frame_valid
);

  if (CLK_DIV < 1 || POLL_PERIOD <= 18 * CLK_DIV + 2) begin : g_bad_params
    $error("pad_reader: CLK_DIV must be >= 1 and POLL_PERIOD > 18*CLK_DIV+2");
  end

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] PH_LAST     = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_LOW_LAST = PW'(CLK_DIV - 1);

  logic tick;

  pad_tick_gen #(
    .POLL_PERIOD(POLL_PERIOD)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick_o(tick)
  );

  pad_state_t          state_q,   state_d;
  logic [PW-1:0]       phase_q,   phase_d;
  logic [2:0]          bit_q,     bit_d;
  logic [PAD_BITS-1:0] shift_q,   shift_d;
  logic [PAD_BITS-1:0] levels_q,  levels_d;
  logic [PAD_BITS-1:0] pressed_q, pressed_d;

  wire phase_end = (phase_q == PH_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      levels_q  <= '0;
      pressed_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      levels_q  <= levels_d;
      pressed_q <= pressed_d;
    end
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (tick) state_d = LATCH;
      LATCH: if (phase_end) state_d = SHIFT;
      SHIFT: if (phase_end && bit_q == 3'd7) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    phase_d   = '0;
    bit_d     = '0;
    shift_d   = shift_q;
    levels_d  = levels_q;
    pressed_d = '0;
    if ((state_q == LATCH || state_q == SHIFT) && !phase_end)
      phase_d = phase_q + 1'b1;
    if (state_q == SHIFT) begin
      bit_d = phase_end ? bit_q + 1'b1 : bit_q;
      if (phase_q == PH_LOW_LAST) shift_d[bit_q] = pad_data;
    end
    // Levels and edge flags load on the edge into DONE so they appear
    // together with frame_valid.
    if (state_q == SHIFT && state_d == DONE) begin
      levels_d  = ~shift_q;
      pressed_d = ~shift_q & ~levels_q;
    end
  end

  always_comb begin
    pad_latch   = (state_q == LATCH);
    pad_clk     = !(state_q == SHIFT && phase_q <= PH_LOW_LAST);
    frame_valid = (state_q == DONE);
  end

  assign btn_atk     = levels_q[BTN_ATK];
  assign btn_shield  = levels_q[BTN_SHIELD];
  assign btn_select  = levels_q[BTN_SELECT];
  assign btn_start   = levels_q[BTN_START];
  assign btn_up      = levels_q[BTN_UP];
  assign btn_down    = levels_q[BTN_DOWN];
  assign btn_left    = levels_q[BTN_LEFT];
  assign btn_right   = levels_q[BTN_RIGHT];
  assign btn_pressed = pressed_q;

endmodule

// File: tb/tb_pad_reader.sv
// Bench for pad_reader: a behavioural controller drives pad_data, and a
// cycle-timeline model predicts every output on every cycle.
module tb_pad_reader;

  localparam int CLK_DIV = 2;
  localparam int POLL    = 100;
  localparam int HALF    = CLK_DIV;
  localparam int LAT_LEN = 2 * CLK_DIV;
  localparam int SCAN    = 18 * CLK_DIV + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pad_data = 1'b1;
  logic       pad_latch, pad_clk, frame_valid;
  logic       btn_atk, btn_shield, btn_select, btn_start;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [7:0] btn_pressed;
  logic [7:0] btn_vec;

  always #5 clk = ~clk;

  pad_reader #(
    .CLK_DIV    (CLK_DIV),
    .POLL_PERIOD(POLL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pad_data   (pad_data),
    .pad_latch  (pad_latch),
    .pad_clk    (pad_clk),
    .btn_atk    (btn_atk),
    .btn_shield (btn_shield),
    .btn_select (btn_select),
    .btn_start  (btn_start),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_pressed(btn_pressed),
    .frame_valid(frame_valid)
  );

  assign btn_vec = {btn_right, btn_left, btn_down, btn_up,
                    btn_start, btn_select, btn_shield, btn_atk};

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Button pattern held by the virtual controller (1 = held).
  logic [7:0] pattern = 8'h00;

  // Timeline model state.
  bit         rst_seen = 1'b0;
  int         cyc = 0;
  bit         busy = 1'b0;
  int         start = 0;
  logic [7:0] snap = 8'h00;
  logic [7:0] exp_levels = 8'h00;
  logic [7:0] exp_pressed = 8'h00;

  // Controller and waveform measurements.
  int  idx = 0;
  bit  prev_pclk = 1'b1;
  int  lat_cnt = 0, pulses = 0, low_run = 0, min_run = 999, max_run = 0;

  always @(posedge clk) rst_seen = rst_n;

  always @(negedge clk) begin
    logic exp_latch, exp_pclk, exp_fv;
    int   off;
    bit   was_idle;
    exp_latch = 1'b0;
    exp_pclk  = 1'b1;
    exp_fv    = 1'b0;
    if (!rst_seen) begin
      cyc = 0;
      busy = 1'b0;
      exp_levels = 8'h00;
      exp_pressed = 8'h00;
    end else begin
      cyc++;
      was_idle = !busy;
      off = cyc - start;
      exp_pressed = 8'h00;
      if (busy) begin
        exp_latch = (off >= 1 && off <= LAT_LEN);
        exp_pclk  = !(off > LAT_LEN && off < SCAN &&
                      ((off - LAT_LEN - 1) % (2 * HALF)) < HALF);
        exp_fv    = (off == SCAN);
      end
      if (exp_fv) begin
        exp_pressed = snap & ~exp_levels;
        exp_levels  = snap;
        busy = 1'b0;
      end
      if (cyc % POLL == POLL - 1 && was_idle) begin
        busy = 1'b1;
        start = cyc;
        snap = pattern;
      end
    end

    check("pad_latch", pad_latch, exp_latch);
    check("pad_clk", pad_clk, exp_pclk);
    check("frame_valid", frame_valid, exp_fv);
    check("btn_levels", btn_vec, exp_levels);
    check("btn_pressed", btn_pressed, exp_pressed);

    if (rst_seen) begin
      if (pad_latch) lat_cnt++;
      if (!pad_clk) low_run++;
      else if (!prev_pclk) begin
        pulses++;
        if (low_run < min_run) min_run = low_run;
        if (low_run > max_run) max_run = low_run;
        low_run = 0;
      end
    end else low_run = 0;

    // Serial controller: latch reloads bit 0, each pad_clk rise advances.
    if (pad_latch) idx = 0;
    else if (pad_clk && !prev_pclk) idx++;
    prev_pclk = pad_clk;
    pad_data = (idx < 8) ? ~pattern[idx] : 1'b1;
  end

  task automatic clear_meas();
    lat_cnt = 0; pulses = 0; min_run = 999; max_run = 0;
  endtask

  task automatic wait_frame(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * POLL && !seen; i++) begin
      @(negedge clk); #1;
      if (frame_valid) seen = 1'b1;
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    logic [7:0] prev;
    bit         hit;

    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    clear_meas();

    // Idle pad: timing of the first scan and an all-released result.
    pattern = 8'h00;
    wait_frame("first");
    check("first_frame_cycle", cyc, 99 + SCAN);
    check("latch_cycles", lat_cnt, 4);
    check("clk_pulses", pulses, 8);
    check("clk_low_min", min_run, 2);
    check("clk_low_max", max_run, 2);
    check("idle_levels", btn_vec, 8'h00);
    check("idle_pressed", btn_pressed, 8'h00);

    // A and Up held.
    pattern = 8'h11;
    wait_frame("a_up");
    check("a_up_atk", btn_atk, 1'b1);
    check("a_up_up", btn_up, 1'b1);
    check("a_up_levels", btn_vec, 8'h11);
    check("a_up_pressed", btn_pressed, 8'h11);
    @(negedge clk); #1;
    check("a_up_pressed_clear", btn_pressed, 8'h00);
    check("a_up_levels_hold", btn_vec, 8'h11);

    // Same pattern again: no new edges.
    wait_frame("hold");
    check("hold_levels", btn_vec, 8'h11);
    check("hold_pressed", btn_pressed, 8'h00);

    // Release A, press Right.
    pattern = 8'h90;
    wait_frame("right");
    check("right_atk", btn_atk, 1'b0);
    check("right_right", btn_right, 1'b1);
    check("right_pressed", btn_pressed, 8'h80);

    // One-cycle reset in the low phase of shift slot 3.
    hit = 1'b0;
    for (int i = 0; i < 3 * POLL && !hit; i++) begin
      @(negedge clk); #1;
      if (busy && cyc - start == LAT_LEN + 1 + 3 * 2 * HALF) hit = 1'b1;
    end
    if (!hit) check("slot3_timeout", 0, 1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("rst_pad_clk", pad_clk, 1'b1);
    check("rst_pad_latch", pad_latch, 1'b0);
    check("rst_frame_valid", frame_valid, 1'b0);
    check("rst_levels", btn_vec, 8'h00);
    rst_n = 1'b1;
    wait_frame("after_rst");
    check("after_rst_cycle", cyc, 99 + SCAN);
    check("after_rst_levels", btn_vec, 8'h90);
    check("after_rst_pressed", btn_pressed, 8'h90);

    // Walking zero on the serial line: each button alone.
    for (int b = 0; b < 8; b++) begin
      prev = btn_vec;
      pattern = 8'h01 << b;
      wait_frame("walk");
      check($sformatf("walk%0d_levels", b), btn_vec, 32'h1 << b);
      check($sformatf("walk%0d_pressed", b), btn_pressed, (32'h1 << b) & ~{24'h0, prev});
    end

    // Random patterns, checked by the timeline model.
    for (int r = 0; r < 6; r++) begin
      pattern = 8'($urandom);
      wait_frame("rand");
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pad_reader.md
PAD_READER -- requirements
Module: pad_reader

Interface
REQ-001 Parameter CLK_DIV, default 300, meaning system clocks per pad_clk half-period (6 us at 50 MHz).
REQ-002 Parameter POLL_PERIOD, default 833333, meaning system clocks between scan starts (60 Hz at 50 MHz).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 pad_data  input  1  serial button data from the NES-style controller; 0 = pressed.
REQ-006 pad_latch  output  1  latch strobe to controller, active high.
REQ-007 pad_clk  output  1  shift clock to controller; idles high.
REQ-008 btn_atk, btn_shield, btn_select, btn_start, btn_up, btn_down, btn_left, btn_right  output  1 each  debounced level, 1 = held (pad bits 0..7, in that order).
REQ-009 btn_pressed  output  8  one-cycle rising-edge flags, bit index = pad bit order.
REQ-010 frame_valid  output  1  one-cycle pulse when new button levels are applied.

Function
REQ-011 Poll counter SHALL count 0..POLL_PERIOD-1 continuously and raise an internal tick on the cycle it holds POLL_PERIOD-1.
REQ-012 States SHALL be IDLE, LATCH, SHIFT, DONE; reset state IDLE.
REQ-013 IDLE: pad_latch=0, pad_clk=1; tick -> LATCH next cycle.
REQ-014 LATCH: pad_latch=1, pad_clk=1 for exactly 2*CLK_DIV cycles -> SHIFT.
REQ-015 SHIFT: 8 bit slots, each a low phase (pad_clk=0, CLK_DIV cycles) followed by a high phase (pad_clk=1, CLK_DIV cycles); 16*CLK_DIV cycles total, pad_latch=0.
REQ-016 pad_data SHALL be sampled on the last cycle of each low phase; slot i sample -> shift bit i.
REQ-017 After the final high phase -> DONE for exactly one cycle -> IDLE.
REQ-018 On DONE: button levels <= inverted samples; btn_pressed <= new & ~old; frame_valid=1; all three visible in the DONE cycle only (btn_pressed and frame_valid zero otherwise).
REQ-019 Latency: tick in cycle T -> frame_valid high in cycle T+18*CLK_DIV+1.
REQ-020 A tick arriving while not IDLE SHALL be ignored (no queued scan).
REQ-021 Button levels SHALL hold their value between DONE cycles.
REQ-022 Phase counter width SHALL be $clog2(2*CLK_DIV); poll counter width $clog2(POLL_PERIOD); no overflow at maximum values.
REQ-023 Elaboration SHALL fail if CLK_DIV<1 or POLL_PERIOD <= 18*CLK_DIV+2.

Reset
REQ-024 With rst_n=0 at a clock edge: state IDLE, counters 0, pad_latch=0, pad_clk=1, all btn_* 0, btn_pressed=0, frame_valid=0.
REQ-025 Reset mid-scan SHALL abort the scan with no frame_valid and no button update; first tick after release starts a clean scan.
REQ-026 Poll counter restarts from 0 on reset release, so the first tick lands POLL_PERIOD-1 cycles after release.

Structure
REQ-027 Shared package smoosh_pkg SHALL hold the state typedef (pad_state_t) and button index constants BTN_ATK=0 .. BTN_RIGHT=7.
REQ-028 One sub-module pad_tick_gen (parameterised poll counter emitting tick) SHALL be used; phase and bit counters stay in pad_reader.
REQ-029 btn_* outputs SHALL drive the fighter top-level state machine's button inputs directly, without further synchronisation.

Verification (CLK_DIV=2, POLL_PERIOD=100)
REQ-030 Reset release, pad_data=1 constant -> pad_latch high 4 cycles, 8 pad_clk low pulses of 2 cycles, frame_valid at tick+37, all btn_*=0, btn_pressed=0.
REQ-031 Model drives bit 0 (A) and bit 4 (Up) low -> btn_atk=1, btn_up=1, others 0, btn_pressed=8'h11 for exactly one cycle.
REQ-032 Same pattern held over a second scan -> levels unchanged, btn_pressed=8'h00 on second frame_valid.
REQ-033 Release A, press Right (bit 7) -> btn_atk=0, btn_right=1, btn_pressed=8'h80.
REQ-034 rst_n low for 1 cycle during SHIFT slot 3 -> pad_clk=1, pad_latch=0 next cycle, no frame_valid, btn_* all 0 until the next full scan completes.
REQ-035 Per-bit walking-zero pattern over 8 scans -> each btn_* asserts alone, confirming bit order and sample timing at low-phase end.
